// File: rtl/mem_access_pkg.sv
// Shared types and encodings for the memory-access stage.
// Contents: datapath widths, FSM state enum, msize/funct3 encodings,
//           writeback packet struct, alignment helper.
package mem_access_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } mem_state_t;

  typedef logic [1:0] msize_t;
  localparam msize_t MSIZE_B = 2'd0;
  localparam msize_t MSIZE_H = 2'd1;
  localparam msize_t MSIZE_W = 2'd2;
  localparam msize_t MSIZE_D = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic              regwrite;
    logic [REG_AW-1:0] dst;
    logic [XLEN-1:0]   result;
    logic              misalign;
  } memory_data_t;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] off, input msize_t size);
    logic mis;
    case (size)
      MSIZE_B: mis = 1'b0;
      MSIZE_H: mis = off[0];
      MSIZE_W: mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus (dbus) bundle between the memory stage and the memory system.
// master: drives dreq_valid/addr/size/strobe/data, receives dresp_*.
// slave : the memory side, the mirror image.
interface mem_access_if;
  import mem_access_pkg::*;

  logic              dreq_valid;
  logic [XLEN-1:0]   dreq_addr;
  logic [2:0]        dreq_size;
  logic [STRB_W-1:0] dreq_strobe;
  logic [XLEN-1:0]   dreq_data;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [XLEN-1:0]   dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/mem_align.sv
// Purely combinational lane alignment for the memory stage.
// Ports: off_i (addr[2:0]), funct3_i (size/sign), wdata_i (rs2), rdata_i
//        (raw lane data); strobe_o, wdata_o (lane-aligned store), rdata_o
//        (shifted and sign/zero-extended load value).
module mem_align
  import mem_access_pkg::*;
(
  input  logic [2:0]        off_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [STRB_W-1:0] strobe_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   rdata_o
);

  logic [STRB_W-1:0] base_mask;
  logic [XLEN-1:0]   rshift;
  logic              sx;

  // Store side: bytes beyond lane 7 fall off the 8-bit strobe.
  always_comb begin
    case (msize_t'(funct3_i[1:0]))
      MSIZE_B: base_mask = 8'h01;
      MSIZE_H: base_mask = 8'h03;
      MSIZE_W: base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
    strobe_o = STRB_W'(base_mask << off_i);
    wdata_o  = wdata_i << {off_i, 3'b000};
  end

  // Load side: bring the addressed byte to lane 0, then extend.
  always_comb begin
    rshift = rdata_i >> {off_i, 3'b000};
    sx     = ~funct3_i[2];
    case (msize_t'(funct3_i[1:0]))
      MSIZE_B: rdata_o = {{(XLEN-8){sx & rshift[7]}},   rshift[7:0]};
      MSIZE_H: rdata_o = {{(XLEN-16){sx & rshift[15]}}, rshift[15:0]};
      MSIZE_W: rdata_o = {{(XLEN-32){sx & rshift[31]}}, rshift[31:0]};
      default: rdata_o = rshift;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV64 memory stage: takes one execute result at a time, runs the dbus
// valid/addr_ok/data_ok handshake for loads/stores and emits a registered
// one-cycle writeback packet.
// Ports: clk, reset (sync, active-high); in_* execute handshake and operands;
//        dbus (mem_access_if.master); out_* writeback packet.
// Build option: MEM_MISALIGN_CHECK_EN -- misaligned memory ops skip the bus
//        and complete with out_misalign set and the address as result.
module mem_access
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_alu,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [REG_AW-1:0] in_dst,
  input  logic              in_regwrite,
  mem_access_if.master      dbus,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_regwrite,
  output logic [REG_AW-1:0] out_dst,
  output logic [XLEN-1:0]   out_result,
  output logic              out_misalign
);

  mem_state_t        state_q, state_d;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              is_load_q, is_load_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic              regwrite_q, regwrite_d;

  logic              dreq_valid_q, dreq_valid_d;
  logic [XLEN-1:0]   dreq_addr_q, dreq_addr_d;
  logic [2:0]        dreq_size_q, dreq_size_d;
  logic [STRB_W-1:0] dreq_strobe_q, dreq_strobe_d;
  logic [XLEN-1:0]   dreq_data_q, dreq_data_d;

  logic              out_valid_q, out_valid_d;
  memory_data_t      out_q, out_d;

  logic [2:0]        al_off_c, al_f3_c;
  logic [STRB_W-1:0] al_strobe_c;
  logic [XLEN-1:0]   al_wdata_c, al_rdata_c;
  memory_data_t      fin_pkt_c;

  // One aligner serves both directions: store lanes are built from the live
  // inputs at accept time, load data is extracted later from latched address.
  assign al_off_c = (state_q == S_IDLE) ? in_alu[2:0] : addr_q[2:0];
  assign al_f3_c  = (state_q == S_IDLE) ? in_funct3   : funct3_q;

  mem_align u_align (
    .off_i    (al_off_c),
    .funct3_i (al_f3_c),
    .wdata_i  (in_wdata),
    .rdata_i  (dbus.dresp_data),
    .strobe_o (al_strobe_c),
    .wdata_o  (al_wdata_c),
    .rdata_o  (al_rdata_c)
  );

  // Packet for a completed bus transaction; stores never write rd.
  always_comb begin
    fin_pkt_c          = '0;
    fin_pkt_c.pc       = pc_q;
    fin_pkt_c.regwrite = regwrite_q & ~is_store_q;
    fin_pkt_c.dst      = dst_q;
    fin_pkt_c.result   = is_load_q ? al_rdata_c : addr_q;
    fin_pkt_c.misalign = 1'b0;
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    is_load_d     = is_load_q;
    is_store_d    = is_store_q;
    funct3_d      = funct3_q;
    addr_d        = addr_q;
    dst_d         = dst_q;
    regwrite_d    = regwrite_q;
    dreq_valid_d  = dreq_valid_q;
    dreq_addr_d   = dreq_addr_q;
    dreq_size_d   = dreq_size_q;
    dreq_strobe_d = dreq_strobe_q;
    dreq_data_d   = dreq_data_q;
    out_valid_d   = 1'b0;
    out_d         = out_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pc_d       = in_pc;
          is_load_d  = in_is_load;
          is_store_d = in_is_store;
          funct3_d   = in_funct3;
          addr_d     = in_alu;
          dst_d      = in_dst;
          regwrite_d = in_regwrite;
          if (!(in_is_load || in_is_store)) begin
            state_d        = S_DONE;
            out_valid_d    = 1'b1;
            out_d.pc       = in_pc;
            out_d.regwrite = in_regwrite;
            out_d.dst      = in_dst;
            out_d.result   = in_alu;
            out_d.misalign = 1'b0;
          end
`ifdef MEM_MISALIGN_CHECK_EN
          else if (is_misaligned(in_alu[2:0], msize_t'(in_funct3[1:0]))) begin
            state_d        = S_DONE;
            out_valid_d    = 1'b1;
            out_d.pc       = in_pc;
            out_d.regwrite = 1'b0;
            out_d.dst      = in_dst;
            out_d.result   = in_alu;
            out_d.misalign = 1'b1;
          end
`endif
          else begin
            state_d       = S_REQ;
            dreq_valid_d  = 1'b1;
            dreq_addr_d   = in_alu;
            dreq_size_d   = {1'b0, in_funct3[1:0]};
            dreq_strobe_d = in_is_store ? al_strobe_c : '0;
            dreq_data_d   = in_is_store ? al_wdata_c  : '0;
          end
        end
      end
      S_REQ: begin
        if (dbus.dresp_addr_ok) begin
          dreq_valid_d = 1'b0;
          if (dbus.dresp_data_ok) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_d       = fin_pkt_c;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dbus.dresp_data_ok) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_d       = fin_pkt_c;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset drops any pending transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b1;
      pc_q          <= '0;
      is_load_q     <= 1'b0;
      is_store_q    <= 1'b0;
      funct3_q      <= '0;
      addr_q        <= '0;
      dst_q         <= '0;
      regwrite_q    <= 1'b0;
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= '0;
      dreq_size_q   <= '0;
      dreq_strobe_q <= '0;
      dreq_data_q   <= '0;
      out_valid_q   <= 1'b0;
      out_q         <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      pc_q          <= pc_d;
      is_load_q     <= is_load_d;
      is_store_q    <= is_store_d;
      funct3_q      <= funct3_d;
      addr_q        <= addr_d;
      dst_q         <= dst_d;
      regwrite_q    <= regwrite_d;
      dreq_valid_q  <= dreq_valid_d;
      dreq_addr_q   <= dreq_addr_d;
      dreq_size_q   <= dreq_size_d;
      dreq_strobe_q <= dreq_strobe_d;
      dreq_data_q   <= dreq_data_d;
      out_valid_q   <= out_valid_d;
      out_q         <= out_d;
    end
  end

  assign in_ready         = ready_q;
  assign dbus.dreq_valid  = dreq_valid_q;
  assign dbus.dreq_addr   = dreq_addr_q;
  assign dbus.dreq_size   = dreq_size_q;
  assign dbus.dreq_strobe = dreq_strobe_q;
  assign dbus.dreq_data   = dreq_data_q;
  assign out_valid        = out_valid_q;
  assign out_pc           = out_q.pc;
  assign out_regwrite     = out_q.regwrite;
  assign out_dst          = out_q.dst;
  assign out_result       = out_q.result;
  assign out_misalign     = out_q.misalign;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the RV64 pipeline. Sits between execute and writeback.
- Accepts one execute-stage result at a time and issues load/store transactions on the data bus (dbus) with a valid/addr_ok/data_ok handshake.
- Aligns and extends load data, builds store strobes, and delivers a registered writeback packet for the regfile and difftest commit.

Parameters:
- XLEN, 64, datapath and address width
- REG_AW, 5, register-index width

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept a new instruction
- in_pc  in  64  instruction PC
- in_is_load  in  1  load op
- in_is_store  in  1  store op
- in_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
- in_alu  in  64  ALU result (effective address for memory ops)
- in_wdata  in  64  store data (rs2)
- in_dst  in  5  destination register
- in_regwrite  in  1  writes rd
- dreq_valid  out  1  dbus request valid
- dreq_addr  out  64  dbus address
- dreq_size  out  3  msize: 0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B
- dreq_strobe  out  8  byte enables; 0 for loads
- dreq_data  out  64  lane-aligned store data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  data returned / store complete
- dresp_data  in  64  raw 64-bit lane data
- out_valid  out  1  writeback packet valid, one-cycle pulse
- out_pc  out  64  committed PC
- out_regwrite  out  1  rd write enable
- out_dst  out  5  rd
- out_result  out  64  writeback value
- out_misalign  out  1  misaligned-access flag (feature only; 0 otherwise)

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset: state IDLE. All of dreq_valid, out_valid, out_regwrite and out_misalign are 0. All data outputs are 0. Pending transactions are dropped: a reset in REQ or WAIT abandons the request and dreq_valid falls on the next edge.
- in_ready = (state == IDLE). On in_valid && in_ready, all inputs are latched.
- IDLE, latched op is neither load nor store -> DONE. out_result = in_alu, out_valid high the next cycle (1-cycle latency).
- IDLE, latched op is load or store -> REQ. dreq_valid is registered and goes high in the following cycle.
- REQ: hold dreq_valid with addr/size/strobe/data stable until dresp_addr_ok.
  - addr_ok && data_ok in the same cycle -> DONE.
  - addr_ok only -> WAIT, and dreq_valid drops.
- WAIT: remain until dresp_data_ok, then -> DONE. Capture dresp_data on that edge.
- DONE: out_valid = 1 for exactly one cycle, then -> IDLE. Writeback has no backpressure.
- dresp_data_ok is ignored in IDLE and DONE.
- dreq_size = funct3[1:0]. dreq_addr = in_alu unmodified.
- Store strobe: base mask (0x01, 0x03, 0x0F, 0xFF by size) shifted left by addr[2:0], truncated to 8 bits.
- Store data: in_wdata shifted left by 8*addr[2:0].
- Load: shift dresp_data right by 8*addr[2:0], then sign-extend (funct3[2] = 0) or zero-extend (funct3[2] = 1) from the access size.
- Stores: out_regwrite forced to 0 regardless of in_regwrite.
- Writes to x0: out_regwrite passes through as given; the regfile ignores them.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - An address not aligned to its size skips REQ/WAIT and goes straight to DONE.
  - out_misalign = 1, out_regwrite = 0, out_result = address.
  - No dbus request is issued.
- Undefined:
  - No check is made. The request is issued as-is; shifted strobe bits beyond lane 7 are dropped.
  - out_misalign is tied to 0.

Decomposition:
- Shared package (pipes):
  - memory_data_t packet (pc, regwrite, dst, result, misalign)
  - mem_state_t enum
  - msize_t and funct3 encodings as localparams
- dbus_req_t/dbus_resp_t stay in common; the flat ports map field-for-field onto them in core.
- One sub-module, mem_align: purely combinational strobe/store-data shifting and load extraction/extension.

Test Plan:
- ALU op, in_alu = 0x1234, rd = 5 -> out_valid exactly 1 cycle later with out_result 0x1234, out_regwrite = 1, out_dst = 5, and no dreq_valid.
- lb at address 0x80000003; bus returns 0x0000_0000_8000_0000 with addr_ok and data_ok in the same cycle -> out_result 0xFFFF_FFFF_FFFF_FF80.
- lwu at address 0x80000004; addr_ok after 3 stall cycles, data_ok 2 cycles later, data 0xDEADBEEF_00000000 -> dreq fields stable throughout, out_result 0x0000_0000_DEAD_BEEF.
- sh at address 0x80000006, rs2 = 0xABCD -> strobe 0xC0, dreq_data 0xABCD_0000_0000_0000, out_regwrite = 0.
- Reset asserted while in WAIT -> the next cycle shows IDLE, in_ready = 1, no out_valid, and a late data_ok is ignored.
- With MEM_MISALIGN_CHECK_EN: lw at address 0x80000002 -> no dreq_valid, out_misalign = 1, out_result 0x80000002.
